// File: rtl/wb_pkg.sv
// Shared encodings and pipeline-register layout for the writeback stage.
package wb_pkg;
  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_LINK = 2'd2;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LHU = 3'd2;
  localparam logic [2:0] LD_LB  = 3'd3;
  localparam logic [2:0] LD_LBU = 3'd4;

  localparam logic [31:0] PC_LINK_OFFSET = 32'd8;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [4:0]  write_addr;
    logic [1:0]  wb_sel;
    logic [2:0]  load_type;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] pc;
  } wb_reg_t;
endpackage

// File: rtl/wb_stage_load_ext.sv
// Combinational load extender: selects a little-endian byte/half lane and
// sign- or zero-extends it. Unknown load types pass the full word.
module load_ext
  import wb_pkg::*;
(
  input  logic [31:0] read_data,
  input  logic [1:0]  addr,
  input  logic [2:0]  load_type,
  output logic [31:0] ext_data
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = read_data[7:0];
    case (addr)
      2'd1:    byte_v = read_data[15:8];
      2'd2:    byte_v = read_data[23:16];
      2'd3:    byte_v = read_data[31:24];
      default: byte_v = read_data[7:0];
    endcase
    // addr[0] is ignored for halfwords
    half_v = addr[1] ? read_data[31:16] : read_data[15:0];
  end

  always_comb begin
    ext_data = read_data;
    case (load_type)
      LD_LH:   ext_data = {{16{half_v[15]}}, half_v};
      LD_LHU:  ext_data = {16'd0, half_v};
      LD_LB:   ext_data = {{24{byte_v[7]}}, byte_v};
      LD_LBU:  ext_data = {24'd0, byte_v};
      default: ext_data = read_data;
    endcase
  end
endmodule

// File: rtl/wb_stage.sv
// MIPS writeback stage: MEM/WB register, result select, GRF write port and
// write-through bypass flags. WB_RETIRE_CNT_EN adds a retired-instruction counter.
module wb_stage
  import wb_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_write_addr,
  input  logic [1:0]  mem_wb_sel,
  input  logic [2:0]  mem_load_type,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_read_data,
  input  logic [31:0] mem_pc,
  input  logic        stall_wb,
  input  logic        flush_wb,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  output logic        reg_write,
  output logic [4:0]  write_addr,
  output logic [31:0] write_data,
  output logic        bypass_rs_grf,
  output logic        bypass_rt_grf,
  output logic        wb_valid
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_count
`endif
);
  wb_reg_t     wb_q, wb_d;
  logic [31:0] ld_data;

  // Flush beats stall; a flushed slot keeps its payload but can never write.
  always_comb begin
    wb_d = wb_q;
    if (flush_wb) begin
      wb_d.valid     = 1'b0;
      wb_d.reg_write = 1'b0;
    end else if (!stall_wb) begin
      wb_d.valid      = mem_valid;
      wb_d.reg_write  = mem_reg_write;
      wb_d.write_addr = mem_write_addr;
      wb_d.wb_sel     = mem_wb_sel;
      wb_d.load_type  = mem_load_type;
      wb_d.alu_result = mem_alu_result;
      wb_d.read_data  = mem_read_data;
      wb_d.pc         = mem_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_q    <= '0;
      wb_q.pc <= RESET_PC;
    end else begin
      wb_q <= wb_d;
    end
  end

  load_ext u_load_ext (
    .read_data (wb_q.read_data),
    .addr      (wb_q.alu_result[1:0]),
    .load_type (wb_q.load_type),
    .ext_data  (ld_data)
  );

  always_comb begin
    case (wb_q.wb_sel)
      WB_SEL_LOAD: write_data = ld_data;
      WB_SEL_LINK: write_data = wb_q.pc + PC_LINK_OFFSET;
      default:     write_data = wb_q.alu_result;
    endcase
  end

  // $0 is hardwired, so writes to it are suppressed and never forwarded
  assign reg_write     = wb_q.valid & wb_q.reg_write & (wb_q.write_addr != 5'd0);
  assign write_addr    = wb_q.write_addr;
  assign wb_valid      = wb_q.valid;
  assign bypass_rs_grf = reg_write & (wb_q.write_addr == id_rs);
  assign bypass_rt_grf = reg_write & (wb_q.write_addr == id_rt);

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_q, retire_d;

  // Counted on the edge the instruction leaves WB, so a stall counts once
  assign retire_d = (wb_q.valid && !stall_wb) ? retire_q + 32'd1 : retire_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) retire_q <= '0;
    else       retire_q <= retire_d;
  end

  assign retire_count = retire_q;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: spec-level model checked every cycle plus
// hand-computed literal expectations on directed vectors.
module tb_wb_stage;
  localparam logic [31:0] RPC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 0, mem_reg_write = 0;
  logic [4:0]  mem_write_addr = 0;
  logic [1:0]  mem_wb_sel = 0;
  logic [2:0]  mem_load_type = 0;
  logic [31:0] mem_alu_result = 0, mem_read_data = 0, mem_pc = 0;
  logic        stall_wb = 0, flush_wb = 0;
  logic [4:0]  id_rs = 0, id_rt = 0;
  logic        reg_write, bypass_rs_grf, bypass_rt_grf, wb_valid;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_count;
`endif

  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 clk = ~clk;

  wb_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_write_addr(mem_write_addr), .mem_wb_sel(mem_wb_sel),
    .mem_load_type(mem_load_type), .mem_alu_result(mem_alu_result),
    .mem_read_data(mem_read_data), .mem_pc(mem_pc),
    .stall_wb(stall_wb), .flush_wb(flush_wb),
    .id_rs(id_rs), .id_rt(id_rt),
    .reg_write(reg_write), .write_addr(write_addr), .write_data(write_data),
    .bypass_rs_grf(bypass_rs_grf), .bypass_rt_grf(bypass_rt_grf),
    .wb_valid(wb_valid)
`ifdef WB_RETIRE_CNT_EN
    , .retire_count(retire_count)
`endif
  );

  // ---------------- behavioural model ----------------
  logic        m_valid, m_rw;
  logic [4:0]  m_addr;
  logic [1:0]  m_sel;
  logic [2:0]  m_lt;
  logic [31:0] m_alu, m_rd, m_pc, m_cnt;

  function automatic logic [31:0] load_val(input logic [2:0] lt, input logic [31:0] ea,
                                           input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * (ea % 4))) & 32'hFF;
    h = (rd >> (16 * ((ea / 2) % 2))) & 32'hFFFF;
    case (lt)
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd2:    return h;
      3'd3:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      default: return rd;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 0; m_rw = 0; m_addr = 0; m_sel = 0; m_lt = 0;
      m_alu = 0; m_rd = 0; m_pc = RPC; m_cnt = 0;
    end else begin
      if (m_valid && !stall_wb) m_cnt = m_cnt + 1;
      if (flush_wb) begin
        m_valid = 0; m_rw = 0;
      end else if (!stall_wb) begin
        m_valid = mem_valid; m_rw = mem_reg_write; m_addr = mem_write_addr;
        m_sel = mem_wb_sel; m_lt = mem_load_type; m_alu = mem_alu_result;
        m_rd = mem_read_data; m_pc = mem_pc;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic        e_rw;
    logic [31:0] e_wd;
    logic [40:0] exp_v, act_v;
    e_rw = m_valid && m_rw && (m_addr != 0);
    if (m_sel == 2'd1)      e_wd = load_val(m_lt, m_alu, m_rd);
    else if (m_sel == 2'd2) e_wd = m_pc + 32'd8;
    else                    e_wd = m_alu;
    exp_v = {e_rw, m_addr, e_wd, e_rw && (m_addr == id_rs), e_rw && (m_addr == id_rt), m_valid};
    act_v = {reg_write, write_addr, write_data, bypass_rs_grf, bypass_rt_grf, wb_valid};
    tot_cnt++;
    if (act_v === exp_v) pass_cnt++;
    else $display("FAIL model_cycle t=%0t actual=%h required=%h", $time, act_v, exp_v);
`ifdef WB_RETIRE_CNT_EN
    tot_cnt++;
    if (retire_count === m_cnt) pass_cnt++;
    else $display("FAIL model_retire t=%0t actual=%0d required=%0d", $time, retire_count, m_cnt);
`endif
  end

  // ---------------- literal checks ----------------
  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
    tot_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  task automatic cap(input logic rw, input logic [4:0] a, input logic [1:0] sel,
                     input logic [2:0] lt, input logic [31:0] alu, input logic [31:0] rd,
                     input logic [31:0] pc);
    mem_valid = 1; mem_reg_write = rw; mem_write_addr = a; mem_wb_sel = sel;
    mem_load_type = lt; mem_alu_result = alu; mem_read_data = rd; mem_pc = pc;
    @(posedge clk); #1;
    mem_valid = 0; mem_reg_write = 0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    lit("rst_reg_write", {31'd0, reg_write}, 32'd0);
    lit("rst_write_data", write_data, 32'd0);
    lit("rst_bypass", {30'd0, bypass_rs_grf, bypass_rt_grf}, 32'd0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    lit("post_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
`ifdef WB_RETIRE_CNT_EN
    lit("post_rst_retire", retire_count, 32'd0);
`endif

    id_rs = 5; id_rt = 6;
    cap(1, 5, 2'd0, 3'd0, 32'h1234_5678, 32'h0, 32'h0);
    lit("alu_reg_write", {31'd0, reg_write}, 32'd1);
    lit("alu_write_addr", {27'd0, write_addr}, 32'd5);
    lit("alu_write_data", write_data, 32'h1234_5678);
    lit("alu_bypass_rs", {31'd0, bypass_rs_grf}, 32'd1);
    lit("alu_bypass_rt", {31'd0, bypass_rt_grf}, 32'd0);

    cap(1, 7, 2'd1, 3'd3, 32'h0000_1003, 32'h80FF_7F01, 0); lit("lb_a3", write_data, 32'hFFFF_FF80);
    cap(1, 7, 2'd1, 3'd4, 32'h0000_1003, 32'h80FF_7F01, 0); lit("lbu_a3", write_data, 32'h0000_0080);
    cap(1, 7, 2'd1, 3'd3, 32'h0000_1001, 32'h80FF_7F01, 0); lit("lb_a1", write_data, 32'h0000_007F);
    cap(1, 7, 2'd1, 3'd1, 32'h0000_1002, 32'h80FF_7F01, 0); lit("lh_a2", write_data, 32'hFFFF_80FF);
    cap(1, 7, 2'd1, 3'd1, 32'h0000_1003, 32'h80FF_7F01, 0); lit("lh_a3", write_data, 32'hFFFF_80FF);
    cap(1, 7, 2'd1, 3'd2, 32'h0000_1000, 32'h80FF_7F01, 0); lit("lhu_a0", write_data, 32'h0000_7F01);
    cap(1, 7, 2'd1, 3'd0, 32'h0000_1000, 32'h80FF_7F01, 0); lit("lw", write_data, 32'h80FF_7F01);
    cap(1, 7, 2'd1, 3'd6, 32'h0000_1001, 32'h80FF_7F01, 0); lit("ld_bad_code", write_data, 32'h80FF_7F01);

    cap(1, 31, 2'd2, 3'd0, 32'h0, 32'h0, 32'hFFFF_FFFC);
    lit("link_wrap", write_data, 32'h0000_0004);
    cap(1, 8, 2'd3, 3'd0, 32'hCAFE_0003, 32'h0, 32'h0);
    lit("sel3_is_alu", write_data, 32'hCAFE_0003);

    id_rs = 0; id_rt = 0;
    cap(1, 0, 2'd0, 3'd0, 32'h0000_DEAD, 32'h0, 32'h0);
    lit("r0_reg_write", {31'd0, reg_write}, 32'd0);
    lit("r0_bypass", {30'd0, bypass_rs_grf, bypass_rt_grf}, 32'd0);
    lit("r0_wb_valid", {31'd0, wb_valid}, 32'd1);

    // stall holding a write, then stall+flush
    id_rs = 4; id_rt = 9;
    mem_valid = 1; mem_reg_write = 1; mem_write_addr = 9; mem_wb_sel = 0;
    mem_alu_result = 32'hAAAA_5555;
    @(posedge clk); #1;
    stall_wb = 1; mem_write_addr = 3; mem_alu_result = 32'h1111_1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      lit("stall_hold_data", write_data, 32'hAAAA_5555);
      lit("stall_hold_bypass_rt", {31'd0, bypass_rt_grf}, 32'd1);
      @(posedge clk); #1;
    end
    flush_wb = 1;
    @(posedge clk); #1;
    flush_wb = 0; stall_wb = 0; mem_valid = 0; mem_reg_write = 0;
    @(negedge clk);
    lit("flush_wb_valid", {31'd0, wb_valid}, 32'd0);
    lit("flush_reg_write", {31'd0, reg_write}, 32'd0);

    // reset asserted in the middle of a stall clears state at once
    cap(1, 4, 2'd0, 3'd0, 32'h5A5A_0000, 32'h0, 32'h0);
    stall_wb = 1;
    @(posedge clk); #2 reset = 1; #1;
    lit("rst_mid_stall_rw", {31'd0, reg_write}, 32'd0);
    lit("rst_mid_stall_data", write_data, 32'd0);
    @(posedge clk); #1 reset = 0; stall_wb = 0;
    cap(1, 12, 2'd2, 3'd0, 32'h0, 32'h0, 32'h0000_3000);
    lit("post_rst_link", write_data, 32'h0000_3008);

    // mixed vectors with stalls and flushes, checked by the model
    for (int i = 0; i < 40; i++) begin
      mem_valid = 1'($urandom); mem_reg_write = 1'($urandom);
      mem_write_addr = 5'($urandom_range(0, 7)); mem_wb_sel = 2'($urandom);
      mem_load_type = 3'($urandom_range(0, 5)); mem_alu_result = $urandom;
      mem_read_data = $urandom; mem_pc = $urandom;
      stall_wb = ($urandom_range(0, 3) == 0); flush_wb = ($urandom_range(0, 5) == 0);
      id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
      @(posedge clk); #1;
    end
    stall_wb = 0; flush_wb = 0; mem_valid = 0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
